// File: rtl/cal_angle_pkg.sv
// rtl/cal_angle_pkg.sv - shared Q3.12 angle constants, CORDIC table and FSM states
// Contents:
//   PI_FIX, PI_DIV_2_FIX  Q3.12 angle constants (pi = 12868)
//   CORDIC_X0             start x with the CORDIC gain pre-divided out (127*64/1.64676)
//   atan_fix()            atan(2^-i) in Q3.12 for i = 0..11
//   state_t               IDLE / ROT / OUT
package cal_angle_pkg;

  localparam logic signed [15:0] PI_FIX       = 16'sd12868;
  localparam logic signed [15:0] PI_DIV_2_FIX = 16'sd6434;
  localparam logic signed [17:0] CORDIC_X0    = 18'sd4936;

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    OUT
  } state_t;

  function automatic logic signed [15:0] atan_fix(input logic [3:0] i);
    case (i)
      4'd0:    return 16'sd3217;
      4'd1:    return 16'sd1899;
      4'd2:    return 16'sd1003;
      4'd3:    return 16'sd509;
      4'd4:    return 16'sd256;
      4'd5:    return 16'sd128;
      4'd6:    return 16'sd64;
      4'd7:    return 16'sd32;
      4'd8:    return 16'sd16;
      4'd9:    return 16'sd8;
      4'd10:   return 16'sd4;
      4'd11:   return 16'sd2;
      default: return 16'sd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_rot_step.sv
// rtl/cordic_rot_step.sv - one combinational rotation-mode CORDIC micro-rotation
// Ports:
//   x, y                  18-bit signed vector, 6 fractional bits
//   z                     16-bit signed residual angle, Q3.12
//   idx                   micro-rotation index (shift amount and table entry)
//   x_next, y_next, z_next  rotated vector and updated residual angle
module cordic_rot_step
  import cal_angle_pkg::*;
(
  input  logic signed [17:0] x,
  input  logic signed [17:0] y,
  input  logic signed [15:0] z,
  input  logic        [3:0]  idx,
  output logic signed [17:0] x_next,
  output logic signed [17:0] y_next,
  output logic signed [15:0] z_next
);

  logic signed [17:0] x_sh;
  logic signed [17:0] y_sh;
  logic signed [15:0] ang;

  always_comb begin
    x_sh = x >>> idx;
    y_sh = y >>> idx;
    ang  = atan_fix(idx);
    // d = +1 when the residual angle is non-negative, otherwise -1
    if (!z[15]) begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - ang;
    end else begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + ang;
    end
  end

endmodule

// File: rtl/cal_iq.sv
// rtl/cal_iq.sv - Q3.12 angle to 8-bit IQ (amplitude 127) via iterative rotation-mode CORDIC
// Build option: CAL_IQ_ROUND_EN selects round-half-away-from-zero output scaling,
//   otherwise the >>>6 truncates. Saturation to -127..127 applies in both builds.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   val_i, angle_i  input strobe and signed Q3.12 angle (pi = 12868), taken only while ready_o = 1
//   ready_o         idle and able to accept an input
//   real_o, imag_o  ~127*cos(angle), ~127*sin(angle); held until the next result
//   val_o           one-cycle pulse marking a new result
module cal_iq
  import cal_angle_pkg::*;
#(
  parameter int ITER = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               val_i,
  input  logic signed [15:0] angle_i,
  output logic               ready_o,
  output logic signed [7:0]  real_o,
  output logic signed [7:0]  imag_o,
  output logic               val_o
);

  localparam logic [3:0] ITER_LAST = 4'(ITER - 1);

  state_t state;
  state_t state_nxt;

  logic        [3:0]  cnt;
  logic signed [17:0] x;
  logic signed [17:0] y;
  logic signed [15:0] z;
  logic               flip;

  logic signed [17:0] x_n;
  logic signed [17:0] y_n;
  logic signed [15:0] z_n;

  logic signed [15:0] a_clamp;
  logic signed [15:0] z_fold;
  logic               flip_fold;
  logic signed [17:0] x_out;
  logic signed [17:0] y_out;

  // Scale the 6-fractional-bit result to an integer and clip to the symmetric range
  function automatic logic signed [7:0] scale_sat(input logic signed [17:0] v);
    logic signed [17:0] s;
`ifdef CAL_IQ_ROUND_EN
    // Round on the magnitude so halves go away from zero on both signs
    if (v[17]) s = -((-v + 18'sd32) >>> 6);
    else       s = (v + 18'sd32) >>> 6;
`else
    s = v >>> 6;
`endif
    if (s > 18'sd127)       return 8'sd127;
    else if (s < -18'sd127) return -8'sd127;
    else                    return s[7:0];
  endfunction

  // Clamp to +-pi, then fold the outer half-plane into +-pi/2 where CORDIC converges;
  // the folded half-turn is undone by negating the result vector.
  always_comb begin
    a_clamp = angle_i;
    if (angle_i > PI_FIX)       a_clamp = PI_FIX;
    else if (angle_i < -PI_FIX) a_clamp = -PI_FIX;

    z_fold    = a_clamp;
    flip_fold = 1'b0;
    if (a_clamp > PI_DIV_2_FIX) begin
      z_fold    = a_clamp - PI_FIX;
      flip_fold = 1'b1;
    end else if (a_clamp < -PI_DIV_2_FIX) begin
      z_fold    = a_clamp + PI_FIX;
      flip_fold = 1'b1;
    end
  end

  cordic_rot_step u_step (
    .x      (x),
    .y      (y),
    .z      (z),
    .idx    (cnt),
    .x_next (x_n),
    .y_next (y_n),
    .z_next (z_n)
  );

  always_comb begin
    x_out = flip ? -x : x;
    y_out = flip ? -y : y;
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (val_i) state_nxt = ROT;
      end
      ROT: begin
        if (cnt == ITER_LAST) state_nxt = OUT;
      end
      OUT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      x      <= 18'sd0;
      y      <= 18'sd0;
      z      <= 16'sd0;
      flip   <= 1'b0;
      real_o <= 8'sd0;
      imag_o <= 8'sd0;
      val_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      val_o <= 1'b0;
      case (state)
        IDLE: begin
          if (val_i) begin
            x    <= CORDIC_X0;
            y    <= 18'sd0;
            z    <= z_fold;
            flip <= flip_fold;
            cnt  <= 4'd0;
          end
        end
        ROT: begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
          if (cnt != ITER_LAST) cnt <= cnt + 4'd1;
        end
        OUT: begin
          real_o <= scale_sat(x_out);
          imag_o <= scale_sat(y_out);
          val_o  <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cal_iq.sv
// tb/tb_cal_iq.sv - self-checking bench for cal_iq (vector table plus scoreboard)
module tb_cal_iq;

  localparam int ITER = 12;
  localparam int LAT  = ITER + 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               val_i = 1'b0;
  logic signed [15:0] angle_i = 16'sd0;
  logic               ready_o;
  logic signed [7:0]  real_o;
  logic signed [7:0]  imag_o;
  logic               val_o;

  always #5 clk = ~clk;

  cal_iq #(.ITER(ITER)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .val_i   (val_i),
    .angle_i (angle_i),
    .ready_o (ready_o),
    .real_o  (real_o),
    .imag_o  (imag_o),
    .val_o   (val_o)
  );

  // Expected outputs are in thousandths of an LSB so model values keep their fraction
  typedef struct {
    int angle;
    int re_m;
    int im_m;
    int tol_m;
  } vec_t;

  typedef struct {
    int angle;
    int re_m;
    int im_m;
    int tol_m;
    int edge_n;
  } sb_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  sb_t    exp_q[$];
  vec_t   cur;
  logic   stream = 1'b0;
  int     acc_count = 0;
  int     last_acc = 0;
  int     last_re = 0;
  int     last_im = 0;
  logic   prev_val = 1'b0;
  logic   done = 1'b0;
  vec_t   tbl[12];

  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  function automatic vec_t model(input int a, input int tol);
    vec_t v;
    int   c;
    real  re;
    real  im;
    c = a;
    if (c > 12868)  c = 12868;
    if (c < -12868) c = -12868;
    re = 127000.0 * $cos(real'(c) / 4096.0);
    im = 127000.0 * $sin(real'(c) / 4096.0);
    v.angle = a;
    v.re_m  = $rtoi(re + ((re >= 0.0) ? 0.5 : -0.5));
    v.im_m  = $rtoi(im + ((im >= 0.0) ? 0.5 : -0.5));
    v.tol_m = tol;
    return v;
  endfunction

  // Input monitor: records every accepted sample with its acceptance edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && val_i && ready_o) begin
        exp_q.push_back('{cur.angle, cur.re_m, cur.im_m, cur.tol_m, cyc});
        if (stream) begin
          if (acc_count > 0) chk("stream_gap", cyc - last_acc, LAT, 0);
          acc_count++;
        end
        last_acc = cyc;
      end
      cyc++;
    end
  end

  // Output monitor: checks each result against the scoreboard and holds between results
  initial begin
    sb_t e;
    int  ang;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_re  = 0;
        last_im  = 0;
        prev_val = 1'b0;
      end else begin
        if (val_o) begin
          chk("val_o_single_cycle", int'(prev_val), 0, 0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_val_o: got val_o=1, expected no result pending at cycle %0d", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("latency", cyc - e.edge_n, LAT, 0);
            chk("real", int'(real_o) * 1000, e.re_m, e.tol_m);
            chk("imag", int'(imag_o) * 1000, e.im_m, e.tol_m);
            chk("real_range", int'(real_o), 0, 127);
            chk("imag_range", int'(imag_o), 0, 127);
            if (e.angle == 3217) begin
              ang = $rtoi($atan2(real'(imag_o), real'(real_o)) * 4096.0 + 0.5);
              chk("loopback_angle", ang, 3217, 40);
            end
          end
          last_re = int'(real_o);
          last_im = int'(imag_o);
        end else begin
          chk("hold_real", int'(real_o), last_re, 0);
          chk("hold_imag", int'(imag_o), last_im, 0);
        end
        prev_val = val_o;
      end
    end
  end

  task automatic send(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(ready_o), 1, 0);
    cur     = v;
    angle_i = 16'(v.angle);
    val_i   = 1'b1;
    @(negedge clk);
    val_i   = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    chk("result_timeout", exp_q.size(), 0, 0);
  endtask

  initial begin
    tbl[0]  = '{0,      127000,  0,       1000};
    tbl[1]  = '{6434,   0,       127000,  1000};
    tbl[2]  = '{-6434,  0,       -127000, 1000};
    tbl[3]  = '{12868,  -127000, 0,       1000};
    tbl[4]  = '{-12868, -127000, 0,       1000};
    tbl[5]  = '{20000,  -127000, 0,       1000};
    tbl[6]  = '{3217,   90000,   90000,   1000};
    tbl[7]  = '{-20000, -127000, 0,       1000};
    tbl[8]  = model(1000, 2000);
    tbl[9]  = model(-5000, 2000);
    tbl[10] = model(9000, 2000);
    tbl[11] = model(-11000, 2000);
    cur = tbl[0];

    // Reset values
    @(negedge clk);
    chk("rst_ready", int'(ready_o), 1, 0);
    chk("rst_val", int'(val_o), 0, 0);
    chk("rst_real", int'(real_o), 0, 0);
    chk("rst_imag", int'(imag_o), 0, 0);
    #2 rst_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      send(tbl[k]);
      wait_done();
    end

    // val_i held high: one acceptance per ITER+2 cycles, the rest dropped
    acc_count = 0;
    stream    = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      cur     = model(int'($urandom_range(40000)) - 20000, 2000);
      angle_i = 16'(cur.angle);
      val_i   = 1'b1;
    end
    @(negedge clk);
    val_i  = 1'b0;
    stream = 1'b0;
    wait_done();
    chk("stream_accepts", acc_count, 5, 0);

    // Reset pulse in the middle of ROT aborts the sample
    send(tbl[6]);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", int'(ready_o), 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", int'(ready_o), 1, 0);
    chk("midrst_val", int'(val_o), 0, 0);
    chk("midrst_real", int'(real_o), 0, 0);
    chk("midrst_imag", int'(imag_o), 0, 0);
    @(negedge clk);
    exp_q.delete();
    #2 rst_n = 1'b1;
    repeat (2 * LAT) @(negedge clk);
    send(tbl[1]);
    wait_done();
    send(tbl[3]);
    wait_done();

    repeat (3) @(negedge clk);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      errors++;
      $display("FAIL watchdog: got no completion, expected finish before time 200000");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

endmodule
